// File: rtl/mem_ctrl.sv
// mem_ctrl: EX/MEM data-memory access controller issuing one bus transaction per load/store.
// Optional MEM_ALIGN_CHECK_EN traps misaligned halfword/word accesses without touching the bus.
//
// state | meaning
// IDLE  | pass writeback through; latch a valid op and stall
// REQ   | bus request held stable until ack
// DONE  | one writeback cycle, never relaunches
module mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   stall_req_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [ADDR_WIDTH-1:0]  bus_addr_o,
  output logic [DATA_WIDTH-1:0]  bus_wdata_o,
  output logic [3:0]             bus_sel_o,
  input  logic                   bus_ack_i,
  input  logic [DATA_WIDTH-1:0]  bus_rdata_i,
  output logic                   misalign_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e                 state;
  logic [3:0]             op_q;
  logic [1:0]             addr_lo_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic                   we_q;
  logic [RDATA_WIDTH-1:0] rdata_q;
  logic                   op_valid;
  logic                   op_misaligned;
  logic                   unused_mem_we;

  function automatic logic is_load(input logic [3:0] op);
    is_load = (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    is_store = (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   lane_sel = 4'b0001 << a;
      OP_SH:   lane_sel = a[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [3:0] op,
                                                       input logic [DATA_WIDTH-1:0] d);
    case (op)
      OP_SB:   store_data = {4{d[7:0]}};
      OP_SH:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_fmt(input logic [3:0] op, input logic [1:0] a,
                                                     input logic [DATA_WIDTH-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   load_fmt = {{(DATA_WIDTH-8){b[7]}}, b};
      OP_LBU:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, b};
      OP_LH:   load_fmt = {{(DATA_WIDTH-16){h[15]}}, h};
      OP_LHU:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, h};
      default: load_fmt = d;
    endcase
  endfunction

  // Bus direction comes from the opcode; the EX/MEM write flag is redundant with it.
  assign unused_mem_we = mem_we_i;
  assign op_valid      = is_load(mem_op_i) || is_store(mem_op_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign op_misaligned =
    (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH)) && mem_addr_i[0]) ||
    (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (mem_addr_i[1:0] != 2'b00));
`else
  assign op_misaligned = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      op_q        <= '0;
      addr_lo_q   <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_sel_o   <= '0;
      misalign_o  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_q      <= mem_op_i;
            addr_lo_q <= mem_addr_i[1:0];
            waddr_q   <= reg_waddr_i;
            we_q      <= reg_we_i;
            rdata_q   <= '0;
            if (op_misaligned) begin
              state      <= S_DONE;
              misalign_o <= 1'b1;
            end else begin
              state       <= S_REQ;
              bus_req_o   <= 1'b1;
              bus_we_o    <= is_store(mem_op_i);
              bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
              bus_sel_o   <= lane_sel(mem_op_i, mem_addr_i[1:0]);
              bus_wdata_o <= store_data(mem_op_i, mem_data_i);
            end
          end
        end
        S_REQ: begin
          if (bus_ack_i) begin
            state     <= S_DONE;
            bus_req_o <= 1'b0;
            if (is_load(op_q)) rdata_q <= load_fmt(op_q, addr_lo_q, bus_rdata_i);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall must rise in the same cycle the op appears so EX/MEM holds it.
  always_comb begin
    stall_req_o = 1'b0;
    reg_waddr_o = reg_waddr_i;
    reg_wdata_o = reg_wdata_i;
    reg_we_o    = reg_we_i;
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          stall_req_o = 1'b1;
          reg_we_o    = 1'b0;
        end
      end
      S_REQ: begin
        stall_req_o = 1'b1;
        reg_we_o    = 1'b0;
      end
      S_DONE: begin
        reg_waddr_o = waddr_q;
        reg_wdata_o = rdata_q;
        reg_we_o    = we_q && is_load(op_q) && !misalign_o;
      end
      default: begin
        stall_req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a transaction-level timeline model drives per-cycle
// expectations, a negedge compare process checks them, plus literal pins for key vectors.
module tb_mem_ctrl;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_op_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stall_req_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        misalign_o;

  mem_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reg_waddr_i (reg_waddr_i),
    .reg_we_i    (reg_we_i),
    .reg_wdata_i (reg_wdata_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_op_i    (mem_op_i),
    .reg_waddr_o (reg_waddr_o),
    .reg_we_o    (reg_we_o),
    .reg_wdata_o (reg_wdata_o),
    .stall_req_o (stall_req_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_sel_o   (bus_sel_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .misalign_o  (misalign_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;
  int txn_cnt   = 0;
  int mis_cnt   = 0;

  logic        chk_en;
  logic        e_stall, e_req, e_mis, e_reg_we, e_chk_rd, e_bz, e_bwe, e_chk_bw;
  logic [4:0]  e_waddr;
  logic [31:0] e_rwdata, e_baddr, e_bwdata;
  logic [3:0]  e_sel;
  logic        in_req, in_done;
  logic        pin_rd_en, pin_sel_en, pin_bw_en, pin_ba_en;
  logic [31:0] pin_rd, pin_bw, pin_ba;
  logic [3:0]  pin_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model of the memory formatting rules.
  function automatic logic m_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic m_is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic m_mis(input logic [3:0] op, input logic [1:0] a);
    return ((op == 4'd2 || op == 4'd5 || op == 4'd7) && a[0]) ||
           ((op == 4'd3 || op == 4'd8) && (a != 2'd0));
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [1:0] a);
    case (op)
      4'd6: case (a)
              2'd0: return 4'b0001;
              2'd1: return 4'b0010;
              2'd2: return 4'b0100;
              default: return 4'b1000;
            endcase
      4'd7: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op)
      4'd6: return (d & 32'h0000_00FF) * 32'h0101_0101;
      4'd7: return (d & 32'h0000_FFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [1:0] a,
                                         input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'h0000_00FF;
    h = (d >> (16 * a[1])) & 32'h0000_FFFF;
    case (op)
      4'd1: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      4'd2: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      4'd4: return b;
      4'd5: return h;
      default: return d;
    endcase
  endfunction

  task automatic clear_exp();
    e_stall = 0; e_req = 0; e_mis = 0; e_reg_we = 0; e_chk_rd = 0; e_bz = 0;
    e_bwe = 0; e_chk_bw = 0; e_waddr = '0; e_rwdata = '0; e_baddr = '0; e_bwdata = '0;
    e_sel = '0; in_req = 0; in_done = 0;
  endtask

  task automatic clear_pins();
    pin_rd_en = 0; pin_sel_en = 0; pin_bw_en = 0; pin_ba_en = 0;
    pin_rd = '0; pin_bw = '0; pin_ba = '0; pin_sel = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("stall_req", 32'(stall_req_o), 32'(e_stall));
      chk("bus_req", 32'(bus_req_o), 32'(e_req));
      chk("misalign", 32'(misalign_o), 32'(e_mis));
      chk("reg_we", 32'(reg_we_o), 32'(e_reg_we));
      if (e_chk_rd) begin
        chk("reg_waddr", 32'(reg_waddr_o), 32'(e_waddr));
        chk("reg_wdata", reg_wdata_o, e_rwdata);
      end
      if (e_req || e_bz) begin
        chk("bus_we", 32'(bus_we_o), 32'(e_bwe));
        chk("bus_addr", bus_addr_o, e_baddr);
        chk("bus_sel", 32'(bus_sel_o), 32'(e_sel));
      end
      if (e_chk_bw || e_bz) chk("bus_wdata", bus_wdata_o, e_bwdata);
      if (in_req && pin_sel_en) chk("pin_sel", 32'(bus_sel_o), 32'(pin_sel));
      if (in_req && pin_bw_en) chk("pin_bus_wdata", bus_wdata_o, pin_bw);
      if (in_req && pin_ba_en) chk("pin_bus_addr", bus_addr_o, pin_ba);
      if (in_done && pin_rd_en) chk("pin_reg_wdata", reg_wdata_o, pin_rd);
      if (stall_req_o) stall_cnt++;
      if (bus_req_o && bus_ack_i) txn_cnt++;
      if (misalign_o) mis_cnt++;
    end
  end

  task automatic nop(input logic [3:0] op, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic ack, input logic bz);
    mem_op_i = op; mem_addr_i = $urandom; mem_data_i = $urandom; mem_we_i = 1'b0;
    reg_we_i = we; reg_waddr_i = wa; reg_wdata_i = wd;
    bus_ack_i = ack; bus_rdata_i = $urandom;
    clear_exp();
    e_reg_we = we; e_chk_rd = 1; e_waddr = wa; e_rwdata = wd; e_bz = bz;
    step();
    bus_ack_i = 1'b0;
  endtask

  // waits = extra REQ cycles before ack (0 = ack in first REQ cycle).
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wa, input logic rwe, input logic [31:0] rdata,
                        input int waits);
    logic ld, st, mis;
    ld  = m_is_load(op);
    st  = m_is_store(op);
    mis = ALIGN_EN && m_mis(op, addr[1:0]);
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data; mem_we_i = st;
    reg_waddr_i = wa; reg_we_i = rwe; reg_wdata_i = $urandom;
    bus_ack_i = 1'b0;
    clear_exp();
    e_stall = 1;
    step();
    if (!mis) begin
      for (int i = 0; i <= waits; i++) begin
        clear_exp();
        e_stall = 1; e_req = 1; e_bwe = st; in_req = 1;
        e_baddr = addr & 32'hFFFF_FFFC;
        e_sel = m_sel(op, addr[1:0]);
        e_chk_bw = st; e_bwdata = m_wdata(op, data);
        bus_ack_i = (i == waits);
        bus_rdata_i = (i == waits) ? rdata : $urandom;
        step();
      end
      bus_ack_i = 1'b0;
    end
    clear_exp();
    e_mis = mis; in_done = 1;
    if (ld && !mis) begin
      e_reg_we = rwe; e_chk_rd = 1; e_waddr = wa; e_rwdata = m_load(op, addr[1:0], rdata);
    end
    step();
    in_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, t0, m0;
    chk_en = 0; rst_i = 1;
    reg_waddr_i = '0; reg_we_i = 0; reg_wdata_i = '0; mem_we_i = 0; mem_addr_i = '0;
    mem_data_i = '0; mem_op_i = '0; bus_ack_i = 0; bus_rdata_i = '0;
    clear_exp(); clear_pins();
    step(); step();
    rst_i = 0; chk_en = 1;

    // Post-reset pass-through, reserved opcode as NOP, stray acks ignored.
    nop(4'd0, 1'b1, 5'd5, 32'h1111_2222, 1'b0, 1'b1);
    nop(4'd12, 1'b1, 5'd9, 32'hA5A5_5A5A, 1'b1, 1'b1);
    nop(4'd15, 1'b0, 5'd3, 32'h0F0F_F0F0, 1'b1, 1'b1);

    // LW with ack in third REQ cycle.
    s0 = stall_cnt;
    pin_rd_en = 1; pin_rd = 32'hDEAD_BEEF;
    access(4'd3, 32'h0000_0100, 32'h0, 5'd4, 1'b1, 32'hDEAD_BEEF, 2);
    clear_pins();
    chk("lw_stall_cycles", 32'(stall_cnt - s0), 32'd4);
    nop(4'd0, 1'b0, 5'd1, 32'h0, 1'b0, 1'b0);

    // Byte loads, signed and unsigned, back to back.
    pin_rd_en = 1; pin_rd = 32'hFFFF_FF80;
    access(4'd1, 32'h0000_0103, 32'h0, 5'd6, 1'b1, 32'h80FF_0000, 0);
    pin_rd = 32'h0000_0080;
    access(4'd4, 32'h0000_0103, 32'h0, 5'd6, 1'b1, 32'h80FF_0000, 0);
    clear_pins();

    access(4'd2, 32'h0000_0102, 32'h0, 5'd8, 1'b1, 32'h8001_1234, 1);
    access(4'd5, 32'h0000_0100, 32'h0, 5'd9, 1'b1, 32'h00FF_F00D, 0);
    nop(4'd0, 1'b1, 5'd2, 32'h7777_8888, 1'b0, 1'b0);

    // Halfword store to upper lane.
    pin_sel_en = 1; pin_sel = 4'b1100; pin_bw_en = 1; pin_bw = 32'hABCD_ABCD;
    access(4'd7, 32'h0000_0202, 32'h1234_ABCD, 5'd10, 1'b1, 32'h5555_5555, 1);
    clear_pins();
    access(4'd6, 32'h0000_0201, 32'h0000_0055, 5'd11, 1'b1, 32'h0, 0);
    access(4'd8, 32'h0000_0300, 32'hCAFE_F00D, 5'd12, 1'b1, 32'h0, 3);
    access(4'd1, 32'h0000_0101, 32'h0, 5'd13, 1'b0, 32'h0000_9A00, 0);
    nop(4'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // Back-to-back SW then LW, ack in first REQ cycle.
    t0 = txn_cnt;
    access(4'd8, 32'h0000_0500, 32'h1357_9BDF, 5'd14, 1'b0, 32'h0, 0);
    access(4'd3, 32'h0000_0500, 32'h0, 5'd15, 1'b1, 32'h2468_ACE0, 0);
    chk("b2b_txn_count", 32'(txn_cnt - t0), 32'd2);
    nop(4'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // Reset in the second REQ cycle abandons the access.
    mem_op_i = 4'd3; mem_addr_i = 32'h0000_0400; mem_data_i = '0; mem_we_i = 0;
    reg_we_i = 1; reg_waddr_i = 5'd7; reg_wdata_i = '0;
    clear_exp(); e_stall = 1;
    step();
    for (int i = 0; i < 2; i++) begin
      clear_exp();
      e_stall = 1; e_req = 1; e_bwe = 0; e_baddr = 32'h0000_0400; e_sel = 4'b1111;
      if (i == 1) rst_i = 1;
      step();
    end
    rst_i = 0;
    t0 = txn_cnt;
    nop(4'd0, 1'b0, 5'd7, 32'h0, 1'b0, 1'b1);
    nop(4'd0, 1'b0, 5'd7, 32'h0, 1'b1, 1'b1);
    nop(4'd0, 1'b0, 5'd7, 32'h0, 1'b0, 1'b1);
    chk("rst_abandon_txns", 32'(txn_cnt - t0), 32'd0);

    // Misaligned word load.
    m0 = mis_cnt; t0 = txn_cnt;
`ifdef MEM_ALIGN_CHECK_EN
    access(4'd3, 32'h0000_0102, 32'h0, 5'd16, 1'b1, 32'h0BAD_F00D, 0);
    chk("mis_pulses", 32'(mis_cnt - m0), 32'd1);
    chk("mis_txns", 32'(txn_cnt - t0), 32'd0);
`else
    pin_ba_en = 1; pin_ba = 32'h0000_0100;
    access(4'd3, 32'h0000_0102, 32'h0, 5'd16, 1'b1, 32'h0BAD_F00D, 0);
    clear_pins();
    chk("mis_pulses", 32'(mis_cnt - m0), 32'd0);
    chk("mis_txns", 32'(txn_cnt - t0), 32'd1);
`endif
    access(4'd2, 32'h0000_0101, 32'h0, 5'd17, 1'b1, 32'h1234_F00D, 0);
    access(4'd7, 32'h0000_0203, 32'h0000_BEEF, 5'd18, 1'b0, 32'h0, 1);
    nop(4'd0, 1'b1, 5'd19, 32'h3C3C_C3C3, 1'b0, 1'b0);
    nop(4'd0, 1'b0, 5'd20, 32'h0, 1'b1, 1'b0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: reg_waddr_i/reg_we_i/reg_wdata_i  in  RADDR_WIDTH/1/RDATA_WIDTH  writeback request from EX/MEM register.
REQ-004 SHALL have ports: mem_we_i, mem_addr_i, mem_data_i, mem_op_i  in  1/ADDR_WIDTH/DATA_WIDTH/4  memory request from EX/MEM register.
REQ-005 SHALL have ports: reg_waddr_o/reg_we_o/reg_wdata_o  out  RADDR_WIDTH/1/RDATA_WIDTH  writeback toward MEM/WB.
REQ-006 SHALL have ports: stall_req_o  out  1  hold EX/MEM and earlier stages.
REQ-007 SHALL have ports: bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o  out  1/1/ADDR_WIDTH/DATA_WIDTH/4  data bus request.
REQ-008 SHALL have ports: bus_ack_i, bus_rdata_i  in  1/DATA_WIDTH  bus completion and read data.
REQ-009 SHALL have ports: misalign_o  out  1  one-cycle misaligned-access pulse.
REQ-010 mem_op codes SHALL be: MEM_NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; codes 9-15 SHALL be treated as MEM_NOP.

Function
REQ-011 FSM states SHALL be IDLE, REQ and DONE.
REQ-012 In IDLE with MEM_NOP, outputs SHALL pass through: reg_*_o = reg_*_i, stall_req_o=0, bus_req_o=0.
REQ-013 In IDLE with a valid op, the block SHALL latch addr, data, op, waddr and we, assert stall_req_o combinationally, and go to REQ next cycle.
REQ-014 In REQ, bus_req_o SHALL be 1, and bus_* outputs SHALL hold stable until the cycle bus_ack_i=1 is sampled.
REQ-015 On ack in REQ, the FSM SHALL go to DONE, latching formatted read data for loads.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally; it SHALL NOT relaunch on the still-present op.
REQ-017 In DONE: stall_req_o=0, bus_req_o=0; loads drive reg_we_o=latched we and reg_wdata_o=load data; stores drive reg_we_o=0.
REQ-018 In IDLE-with-op and in REQ, reg_we_o SHALL be 0 (bubble).
REQ-019 Minimum latency: op at cycle 0, req at cycle 1, ack at cycle 1, writeback in cycle 2; each extra wait cycle adds one.
REQ-020 bus_addr_o SHALL be {mem_addr[ADDR_WIDTH-1:2],2'b00}; little-endian lanes.
REQ-021 bus_sel_o SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011 (addr[1]=0) or 4'b1100; SW 4'b1111; loads 4'b1111.
REQ-022 bus_wdata_o SHALL be: SB byte replicated x4; SH half replicated x2; SW unchanged.
REQ-023 Loads SHALL select the byte/half by addr[1:0]/addr[1]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-024 bus_ack_i outside REQ SHALL be ignored.

Reset
REQ-025 rst_i SHALL force the state to IDLE and clear all latched registers and the misalign pulse.
REQ-026 The cycle after reset, outputs SHALL be: bus_req_o=0, bus_we_o=0, bus_sel_o=0, bus_addr_o=0, bus_wdata_o=0, misalign_o=0; reg_*_o and stall_req_o follow REQ-012/013 from inputs.
REQ-027 Reset during REQ SHALL abandon the access (bus_req_o=0 next cycle) with no writeback.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL skip REQ, go IDLE->DONE with bus_req_o never asserted, misalign_o=1 and reg_we_o=0 in DONE.
REQ-029 Macro MEM_ALIGN_CHECK_EN undefined: misalign_o SHALL be tied 0, and low address bits beyond REQ-021/023 selection SHALL be ignored.

Verification
REQ-030 LW addr 0x100, bus_rdata 0xDEADBEEF, ack after 3 REQ cycles -> stall_req_o high 4 cycles; DONE reg_wdata_o=0xDEADBEEF, reg_we_o=1.
REQ-031 LB addr 0x103, rdata 0x80FF0000 -> reg_wdata_o=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-032 SH addr 0x202, data 0x1234ABCD -> bus_sel_o=4'b1100, bus_wdata_o=0xABCDABCD, bus_we_o=1, DONE reg_we_o=0.
REQ-033 Reset asserted in the 2nd REQ cycle -> bus_req_o=0 next cycle, no writeback, a later ack is ignored.
REQ-034 With MEM_ALIGN_CHECK_EN defined, LW addr 0x102 -> bus_req_o stays 0 and misalign_o pulses one cycle; without it, the bus reads address 0x100.
REQ-035 Back-to-back SW then LW with an ack in the first REQ cycle -> two distinct bus transactions, each followed by exactly one DONE cycle.
